keysched_des_seq: RTL and testbench
===================================

KEYSCHED_DES_SEQ -- requirements
Module: keysched_des_seq

Interface
REQ-001 SHALL have parameter NKEY, default 1, number of 64-bit DES keys (legal 1 = single DES, 3 = 3DES EDE).
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request a new schedule.
REQ-005 SHALL have port dec, input, 1, 0 = encrypt order, 1 = decrypt order; sampled with start.
REQ-006 SHALL have port key_in, input, 64*NKEY, keys; key 1 in the MSB 64 bits; within each key MSB = FIPS bit 1.
REQ-007 SHALL have port busy, output, 1, schedule in progress.
REQ-008 SHALL have port sk_valid, output, 1, subkey presented.
REQ-009 SHALL have port sk_ready, input, 1, consumer accepts subkey.
REQ-010 SHALL have port subkey, output, 48, current subkey; MSB = FIPS bit 1.
REQ-011 SHALL have port sk_idx, output, 6, output ordinal 0..16*NKEY-1.
REQ-012 SHALL have port sk_last, output, 1, high with the final subkey.
REQ-013 SHALL have port parity_err, output, 1, one-cycle key parity failure pulse.

Function
REQ-014 SHALL implement states IDLE, LOAD, GEN; IDLE->LOAD on start, LOAD->GEN after one cycle, GEN->IDLE on handshake of the sk_last beat.
REQ-015 SHALL register key_in and dec on the cycle start is accepted in IDLE; start while busy SHALL be ignored.
REQ-016 SHALL apply PC-1 to the active key in LOAD, producing C0/D0 (28 bits each).
REQ-017 SHALL assert sk_valid first in the second cycle after start acceptance (latency 2) and keep it high through GEN.
REQ-018 SHALL advance to the next subkey only on sk_valid && sk_ready; otherwise subkey, sk_idx, sk_last SHALL hold stable.
REQ-019 Encrypt pass SHALL emit K1..K16: rotate C/D left by schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 before each PC-2.
REQ-020 Decrypt pass SHALL emit K16..K1: first beat PC-2(C0D0) unrotated; subsequent beats rotate C/D right by schedule entries 16 down to 2.
REQ-021 With NKEY=3, dec=0 SHALL run passes key1-encrypt, key2-decrypt, key3-encrypt; dec=1 SHALL run key3-decrypt, key2-encrypt, key1-decrypt; each pass reloads PC-1 in one internal cycle with sk_valid low.
REQ-022 busy SHALL be high from the cycle after start acceptance until the cycle after the sk_last handshake.
REQ-023 sk_idx SHALL increment by one per handshake and never wrap within a schedule.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, busy=0, sk_valid=0, sk_last=0, sk_idx=0, subkey=0, parity_err=0, at any point including mid-schedule.
REQ-025 After reset release, the first start SHALL begin a fresh schedule with no residue of an aborted one.

Configuration
REQ-026 Macro KEYSCHED_PARITY_CHECK_EN defined: on start, every key byte SHALL be checked for odd parity; any failure SHALL pulse parity_err one cycle after start, return to IDLE, emit no subkeys.
REQ-027 Macro undefined: parity bits SHALL be ignored and parity_err tied 0.

Structure
REQ-028 Package des_pkg SHALL hold PC-1 and PC-2 tables, the 16-entry shift schedule, and the state enum.
REQ-029 PC-2 SHALL be a combinational sub-module des_pc2_perm instantiated once.

Verification
REQ-030 key 133457799BBCDFF1, dec=0, sk_ready=1 -> first subkey 1B02EFFC7072 at cycle 2, sk_idx 15 = CB3D8B0E17F5 with sk_last=1.
REQ-031 same key, dec=1 -> first subkey CB3D8B0E17F5, last 1B02EFFC7072.
REQ-032 sk_ready low 5 cycles at sk_idx=3 -> subkey/sk_idx stable throughout; sequence unchanged vs REQ-030.
REQ-033 NKEY=3, three keys 133457799BBCDFF1, dec=0 -> 48 beats; sk_idx 16 = CB3D8B0E17F5, sk_idx 47 = CB3D8B0E17F5, sk_last at 47 only.
REQ-034 rst_n low at sk_idx=7 -> sk_valid=0 immediately; next start yields 1B02EFFC7072 first.
REQ-035 With KEYSCHED_PARITY_CHECK_EN, key 0000000000000000 -> parity_err pulse, no sk_valid; key 0101010101010101 -> normal schedule.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES key-schedule tables, state encoding and bit-permutation helpers.
package des_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StLoad = 2'd1;
  localparam state_t StGen  = 2'd2;

  // PC-1: 64-bit key (bit 1 = MSB) to 56-bit C0D0
  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: 56-bit CD to 48-bit subkey
  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotation amount applied before round i+1
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [55:0] pc1_perm(input logic [63:0] key);
    logic [55:0] p;
    p = '0;
    for (int i = 0; i < 56; i++) begin
      p[6'(55 - i)] = key[6'(64 - PC1[i])];
    end
    return p;
  endfunction

  // Rotate C and D halves independently by 1 or 2 places
  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic [1:0] n,
                                         input logic right);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (right) begin
      if (n == 2'd2) begin
        c = {c[1:0], c[27:2]};
        d = {d[1:0], d[27:2]};
      end else begin
        c = {c[0], c[27:1]};
        d = {d[0], d[27:1]};
      end
    end else begin
      if (n == 2'd2) begin
        c = {c[25:0], c[27:26]};
        d = {d[25:0], d[27:26]};
      end else begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
    end
    return {c, d};
  endfunction

  // High when any byte of the key has even parity
  function automatic logic key_parity_bad(input logic [63:0] key);
    logic       bad;
    logic [7:0] by;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      by  = 8'(key >> (8 * b));
      bad = bad | ~(^by);
    end
    return bad;
  endfunction

endpackage

// File: rtl/des_pc2_perm.sv
// Combinational PC-2 permutation: 56-bit CD register to 48-bit round subkey.
module des_pc2_perm
  import des_pkg::*;
(
  input  logic [55:0] cd_i,
  output logic [47:0] subkey_o
);

  // Pure bit permutation
  always_comb begin
    subkey_o = '0;
    for (int i = 0; i < 48; i++) begin
      subkey_o[6'(47 - i)] = cd_i[6'(56 - PC2[i])];
    end
  end

endmodule

// File: rtl/keysched_des_seq.sv
// Sequential DES / 3DES-EDE key scheduler emitting one 48-bit subkey per
// valid/ready handshake. Optional key parity checking is enabled by defining
// KEYSCHED_PARITY_CHECK_EN.
module keysched_des_seq
  import des_pkg::*;
#(
  parameter int unsigned NKEY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               dec,
  input  logic [64*NKEY-1:0] key_in,
  output logic               busy,
  output logic               sk_valid,
  input  logic               sk_ready,
  output logic [47:0]        subkey,
  output logic [5:0]         sk_idx,
  output logic               sk_last,
  output logic               parity_err
);

  localparam int unsigned KW = 64 * NKEY;

  state_t      state_q, state_d;
  logic [KW-1:0] key_q, key_d;
  logic        dec_q, dec_d;
  logic [1:0]  pass_q, pass_d;
  logic [3:0]  round_q, round_d;
  logic [55:0] cd_q, cd_d;
  logic [47:0] subkey_q, subkey_d;
  logic [5:0]  idx_q, idx_d;
  logic        last_q, last_d;

  logic          mode_dec;
  logic          last_pass;
  int unsigned   kidx;
  logic [KW-1:0] key_sh;
  logic [63:0]   act_key;
  logic          parity_bad;
  logic [47:0]   pc2_out;

  // Key and direction of the current pass; 3DES alternates direction per pass
  always_comb begin
    mode_dec  = dec_q ^ pass_q[0];
    last_pass = (32'(pass_q) == NKEY - 1);
    kidx      = dec_q ? (NKEY - 1 - 32'(pass_q)) : 32'(pass_q);
    key_sh    = key_q << (64 * kidx);
    act_key   = key_sh[KW-1 -: 64];
  end

`ifdef KEYSCHED_PARITY_CHECK_EN
  logic parity_err_q, parity_err_d;

  // Odd parity required on every byte of every key
  always_comb begin
    parity_bad = 1'b0;
    for (int k = 0; k < int'(NKEY); k++) begin
      parity_bad = parity_bad | key_parity_bad(64'(key_in >> (64 * k)));
    end
    parity_err_d = (state_q == StIdle) && start && parity_bad;
  end

  // One-cycle parity failure pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  assign parity_bad = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Next C/D: PC-1 on load, then one rotation step per accepted beat
  always_comb begin
    cd_d = cd_q;
    case (state_q)
      StLoad: begin
        // Decrypt starts from C16D16, which equals C0D0
        cd_d = mode_dec ? pc1_perm(act_key) : rot_cd(pc1_perm(act_key), SHIFT[0], 1'b0);
      end
      StGen: begin
        if (sk_ready && (round_q != 4'd15)) begin
          cd_d = mode_dec ? rot_cd(cd_q, SHIFT[4'd15 - round_q], 1'b1)
                          : rot_cd(cd_q, SHIFT[round_q + 4'd1], 1'b0);
        end
      end
      default: ;
    endcase
  end

  des_pc2_perm u_pc2 (
    .cd_i    (cd_d),
    .subkey_o(pc2_out)
  );

  // Control FSM and output registers
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    dec_d    = dec_q;
    pass_d   = pass_q;
    round_d  = round_q;
    subkey_d = subkey_q;
    idx_d    = idx_q;
    last_d   = last_q;
    case (state_q)
      StIdle: begin
        if (start && !parity_bad) begin
          key_d   = key_in;
          dec_d   = dec;
          pass_d  = 2'd0;
          idx_d   = 6'd0;
          last_d  = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        subkey_d = pc2_out;
        round_d  = 4'd0;
        last_d   = 1'b0;
        state_d  = StGen;
      end
      StGen: begin
        if (sk_ready) begin
          if (round_q == 4'd15) begin
            last_d = 1'b0;
            if (last_pass) begin
              state_d = StIdle;
            end else begin
              pass_d  = pass_q + 2'd1;
              idx_d   = idx_q + 6'd1;
              state_d = StLoad;
            end
          end else begin
            round_d  = round_q + 4'd1;
            idx_d    = idx_q + 6'd1;
            subkey_d = pc2_out;
            last_d   = (round_q == 4'd14) && last_pass;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      key_q    <= '0;
      dec_q    <= 1'b0;
      pass_q   <= 2'd0;
      round_q  <= 4'd0;
      cd_q     <= '0;
      subkey_q <= '0;
      idx_q    <= 6'd0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      dec_q    <= dec_d;
      pass_q   <= pass_d;
      round_q  <= round_d;
      cd_q     <= cd_d;
      subkey_q <= subkey_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign sk_valid = (state_q == StGen);
  assign subkey   = subkey_q;
  assign sk_idx   = idx_q;
  assign sk_last  = last_q;

endmodule

// File: tb/tb_keysched_des_seq.sv
// Scoreboard bench for keysched_des_seq: single-DES and 3DES instances.
module tb_keysched_des_seq;
  import des_pkg::*;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start1 = 1'b0, dec1 = 1'b0, rdy1 = 1'b1;
  logic [63:0]   key1 = '0;
  logic          busy1, val1, last1, perr1;
  logic [47:0]   sk1;
  logic [5:0]    idx1;

  logic          start3 = 1'b0, dec3 = 1'b0, rdy3 = 1'b1;
  logic [191:0]  key3 = '0;
  logic          busy3, val3, last3, perr3;
  logic [47:0]   sk3;
  logic [5:0]    idx3;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard entries: {last, idx[5:0], subkey[47:0]}
  logic [54:0] q1[$];
  logic [54:0] q3[$];
  logic [47:0] cap1 [16];
  logic [47:0] cap3 [48];

  keysched_des_seq #(.NKEY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dec(dec1), .key_in(key1),
    .busy(busy1), .sk_valid(val1), .sk_ready(rdy1), .subkey(sk1), .sk_idx(idx1),
    .sk_last(last1), .parity_err(perr1)
  );

  keysched_des_seq #(.NKEY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .dec(dec3), .key_in(key3),
    .busy(busy3), .sk_valid(val3), .sk_ready(rdy3), .subkey(sk3), .sk_idx(idx3),
    .sk_last(last3), .parity_err(perr3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: rotate C0/D0 by the cumulative shift for round rnd (1..16)
  function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int rnd);
    logic [55:0] cd;
    logic [27:0] c, d, cr, dr;
    logic [47:0] o;
    int tot;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = k[6'(64 - PC1[i])];
    c = cd[55:28];
    d = cd[27:0];
    tot = 0;
    for (int i = 0; i < rnd; i++) tot += int'(SHIFT[i]);
    for (int j = 0; j < 28; j++) begin
      cr[5'(27 - j)] = c[5'(27 - ((j + tot) % 28))];
      dr[5'(27 - j)] = d[5'(27 - ((j + tot) % 28))];
    end
    cd = {cr, dr};
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2[i])];
    return o;
  endfunction

  function automatic logic [63:0] fix_parity(input logic [63:0] k);
    logic [63:0] o;
    logic [7:0]  by;
    o = '0;
    for (int b = 0; b < 8; b++) begin
      by = 8'(k >> (8 * b));
      if (!(^by)) by[0] = ~by[0];
      o = o | (64'(by) << (8 * b));
    end
    return o;
  endfunction

  task automatic push_pass(input int which, input logic [63:0] k, input logic d,
                           input int base, input bit final_pass);
    logic [54:0] ent;
    for (int b = 0; b < 16; b++) begin
      ent = {final_pass && (b == 15), 6'(base + b), ref_subkey(k, d ? 16 - b : b + 1)};
      if (which == 1) q1.push_back(ent);
      else            q3.push_back(ent);
    end
  endtask

  // Monitors: compare presented beat with scoreboard head; pop on handshake
  always @(negedge clk) begin
    if (rst_n && val1) begin
      if (q1.size() == 0) check("d1 unexpected beat", 64'(idx1), 64'h3f);
      else begin
        check($sformatf("d1 beat%0d", q1[0][53:48]), 64'({last1, idx1, sk1}), 64'(q1[0]));
        if (rdy1) begin
          cap1[idx1[3:0]] = sk1;
          void'(q1.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && val3) begin
      if (q3.size() == 0) check("d3 unexpected beat", 64'(idx3), 64'h3f);
      else begin
        check($sformatf("d3 beat%0d", q3[0][53:48]), 64'({last3, idx3, sk3}), 64'(q3[0]));
        if (rdy3) begin
          if (idx3 < 6'd48) cap3[idx3] = sk3;
          void'(q3.pop_front());
        end
      end
    end
  end

  task automatic run1(input logic [63:0] k, input logic d);
    push_pass(1, k, d, 0, 1'b1);
    @(posedge clk); #1;
    start1 = 1'b1; dec1 = d; key1 = k;
    @(posedge clk); #1;
    start1 = 1'b0; dec1 = ~d; key1 = ~k;
    @(negedge clk);
    check("d1 busy in load", 64'(busy1), 64'd1);
    check("d1 valid in load", 64'(val1), 64'd0);
    check("d1 parity_err quiet", 64'(perr1), 64'd0);
    @(negedge clk);
    check("d1 valid latency 2", 64'(val1), 64'd1);
  endtask

  task automatic run3(input logic [191:0] kk, input logic d);
    logic [63:0] k;
    int ki;
    for (int p = 0; p < 3; p++) begin
      ki = d ? 2 - p : p;
      k  = 64'(kk >> (64 * (2 - ki)));
      push_pass(3, k, d ^ (p % 2 == 1), 16 * p, p == 2);
    end
    @(posedge clk); #1;
    start3 = 1'b1; dec3 = d; key3 = kk;
    @(posedge clk); #1;
    start3 = 1'b0; dec3 = ~d; key3 = ~kk;
    @(negedge clk);
    check("d3 valid in load", 64'(val3), 64'd0);
    @(negedge clk);
    check("d3 valid latency 2", 64'(val3), 64'd1);
  endtask

  task automatic wait_drain(input int which, input int budget);
    int n;
    n = 0;
    while (((which == 1) ? q1.size() : q3.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (which == 1) begin
      if (q1.size() != 0) begin
        check("d1 drain timeout", 64'(q1.size()), 64'd0);
        q1.delete();
      end
    end else begin
      if (q3.size() != 0) begin
        check("d3 drain timeout", 64'(q3.size()), 64'd0);
        q3.delete();
      end
    end
    repeat (2) @(negedge clk);
    if (which == 1) check("d1 idle after schedule", 64'({busy1, val1}), 64'd0);
    else            check("d3 idle after schedule", 64'({busy3, val3}), 64'd0);
  endtask

  // Advance until DUT1 presents the given index (head of scoreboard)
  task automatic wait_idx1(input logic [5:0] target);
    int n;
    n = 0;
    while (!(q1.size() > 0 && q1[0][53:48] == target) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("d1 wait for index", 64'(idx1), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset d1 outputs", 64'({busy1, val1, last1, perr1, idx1}), 64'd0);
    check("reset d1 subkey", 64'(sk1), 64'd0);
    check("reset d3 outputs", 64'({busy3, val3, last3, perr3, idx3}), 64'd0);
    rst_n = 1'b1;

    // Encrypt then decrypt order on the reference key
    run1(KEY_A, 1'b0);
    wait_drain(1, 100);
    check("enc first subkey", 64'(cap1[0]), 64'h1B02EFFC7072);
    check("enc last subkey", 64'(cap1[15]), 64'hCB3D8B0E17F5);
    run1(KEY_A, 1'b1);
    wait_drain(1, 100);
    check("dec first subkey", 64'(cap1[0]), 64'hCB3D8B0E17F5);
    check("dec last subkey", 64'(cap1[15]), 64'h1B02EFFC7072);

    // Back-pressure at index 3, plus an ignored start while busy
    run1(KEY_A, 1'b0);
    wait_idx1(6'd3);
    rdy1 = 1'b0;
    start1 = 1'b1; dec1 = 1'b1; key1 = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rdy1 = 1'b1;
    wait_drain(1, 100);
    check("stall first subkey", 64'(cap1[0]), 64'h1B02EFFC7072);
    check("stall last subkey", 64'(cap1[15]), 64'hCB3D8B0E17F5);

    // Other key patterns
    run1(64'h0101010101010101, 1'b0);
    wait_drain(1, 100);
    for (int t = 0; t < 2; t++) begin
      run1(fix_parity({$urandom(), $urandom()}), 1'($urandom_range(1)));
      wait_drain(1, 100);
    end

`ifdef KEYSCHED_PARITY_CHECK_EN
    @(posedge clk); #1;
    start1 = 1'b1; dec1 = 1'b0; key1 = 64'h0;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    check("parity_err pulse", 64'(perr1), 64'd1);
    check("parity fail not busy", 64'(busy1), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("parity fail no beats", 64'({perr1, val1}), 64'd0);
    end
`else
    run1(64'h0, 1'b0);
    wait_drain(1, 100);
`endif

    // 3DES EDE, identical keys, encrypt
    run3({3{KEY_A}}, 1'b0);
    wait_drain(3, 300);
    check("3des idx0", 64'(cap3[0]), 64'h1B02EFFC7072);
    check("3des idx16", 64'(cap3[16]), 64'hCB3D8B0E17F5);
    check("3des idx47", 64'(cap3[47]), 64'hCB3D8B0E17F5);

    // 3DES, distinct keys, decrypt order
    run3({KEY_A, fix_parity(64'hA5A55A5A0F0FF0F0), fix_parity({$urandom(), $urandom()})},
         1'b1);
    wait_drain(3, 300);

    // Asynchronous reset in the middle of a schedule
    run1(KEY_A, 1'b0);
    wait_idx1(6'd7);
    #2 rst_n = 1'b0;
    #1;
    check("abort valid/busy", 64'({val1, busy1, last1, perr1}), 64'd0);
    check("abort idx", 64'(idx1), 64'd0);
    check("abort subkey", 64'(sk1), 64'd0);
    q1.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    run1(KEY_A, 1'b0);
    wait_drain(1, 100);
    check("after abort first", 64'(cap1[0]), 64'h1B02EFFC7072);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
